// File: rtl/ysyx_25010008_ifu_pkg.sv
// Shared fetch/load-store definitions: controller state encoding and memory response codes.
package ysyx_25010008_ifu_pkg;

    typedef enum logic [2:0] {
        S_AR,
        S_R,
        S_HOLD,
        S_WAIT,
        S_HALT
    } ifu_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_25010008_ifu_if.sv
// Single-outstanding AR/R read port between a fetch/LSU master and instruction memory.
interface ysyx_25010008_ifu_if;

    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/ysyx_25010008_wdt.sv
// Bus watchdog: down-counter reloaded on clear or while idle, expires on its TIMEOUT-th enabled cycle.
module ysyx_25010008_wdt #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (clr || !en) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/ysyx_25010008_ifu.sv
// Multi-cycle instruction fetch: one word read per instruction, handed to decode, then wait for npc.
//  state  | meaning
//  S_AR   | presenting pc on the read-address channel
//  S_R    | address accepted, waiting for read data
//  S_HOLD | inst/pc offered to decode
//  S_WAIT | inst consumed, waiting for npc or halt from writeback
//  S_HALT | stopped (halt or fault) until reset
module ysyx_25010008_ifu
    import ysyx_25010008_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 npc,
    input  logic                        npc_valid,
    input  logic                        halt_req,
    ysyx_25010008_ifu_if.master         imem,
    output logic [31:0]                 inst,
    output logic [31:0]                 pc,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    output logic                        fetch_err,
    output logic                        halted,
    output logic [31:0]                 fetch_cnt
);

    ifu_state_e state;
    logic       arvalid_q;
    logic       rready_q;
    logic       wdt_expired;

    assign imem.arvalid = arvalid_q;
    assign imem.araddr  = pc;
    assign imem.rready  = rready_q;

    // Address acceptance restarts the budget so S_R gets its own full window.
    ysyx_25010008_wdt #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (arvalid_q && imem.arready),
        .en      ((state == S_AR) || (state == S_R)),
        .expired (wdt_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_AR;
            pc         <= RESET_PC;
            inst       <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
            halted     <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            case (state)
                S_AR: begin
                    if (arvalid_q && imem.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_R;
                    end else if (wdt_expired) begin
                        arvalid_q <= 1'b0;
                        fetch_err <= 1'b1;
                        halted    <= 1'b1;
                        state     <= S_HALT;
                    end else begin
                        arvalid_q <= 1'b1;
                    end
                end
                S_R: begin
                    if (rready_q && imem.rvalid) begin
                        rready_q <= 1'b0;
                        if (imem.rresp == RESP_OKAY) begin
                            inst       <= imem.rdata;
                            fetch_cnt  <= fetch_cnt + 32'd1;
                            inst_valid <= 1'b1;
                            state      <= S_HOLD;
                        end else begin
                            fetch_err <= 1'b1;
                            halted    <= 1'b1;
                            state     <= S_HALT;
                        end
                    end else if (wdt_expired) begin
                        rready_q  <= 1'b0;
                        fetch_err <= 1'b1;
                        halted    <= 1'b1;
                        state     <= S_HALT;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A retiring ebreak wins over a redirect arriving in the same cycle.
                    if (halt_req) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (npc_valid) begin
                        if (npc[1:0] != 2'b00) begin
                            fetch_err <= 1'b1;
                            halted    <= 1'b1;
                            state     <= S_HALT;
                        end else begin
                            pc        <= npc;
                            arvalid_q <= 1'b1;
                            state     <= S_AR;
                        end
                    end
                end
                S_HALT: begin
                end
                default: begin
                    halted <= 1'b1;
                    state  <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_ifu.sv
// Directed + randomized bench for the fetch stage against a word-addressed memory/PC-sequence model.
module tb_ysyx_25010008_ifu;
    import ysyx_25010008_ifu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          TMO      = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] npc = '0;
    logic        npc_valid = 1'b0;
    logic        halt_req = 1'b0;
    logic        inst_ready = 1'b0;
    logic [31:0] inst, pc, fetch_cnt;
    logic        inst_valid, fetch_err, halted;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt;
    logic [31:0] mem [logic [31:0]];

    ysyx_25010008_ifu_if imem ();

    ysyx_25010008_ifu #(.RESET_PC(RESET_PC), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .npc        (npc),
        .npc_valid  (npc_valid),
        .halt_req   (halt_req),
        .imem       (imem),
        .inst       (inst),
        .pc         (pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err),
        .halted     (halted),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    task automatic quiet_inputs();
        npc_valid    = 1'b0;
        halt_req     = 1'b0;
        inst_ready   = 1'b0;
        imem.arready = 1'b0;
        imem.rvalid  = 1'b0;
        imem.rresp   = RESP_OKAY;
        imem.rdata   = $urandom;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        quiet_inputs();
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
    endtask

    // Memory side of one fetch; noise on inputs the fetch stage must ignore while busy.
    task automatic fetch(input logic [31:0] addr, input int ar_dly, input int r_dly,
                         input logic [1:0] resp, input logic [31:0] data);
        int n = 0;
        while (imem.arvalid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("ar_wait_bound", 32'(n < 40), 32'd1);
        chk("araddr", imem.araddr, addr);
        for (int i = 0; i < ar_dly; i++) begin
            npc_valid   = 1'($urandom);
            halt_req    = 1'($urandom);
            npc         = $urandom;
            imem.rvalid = 1'($urandom);
            tick();
            chk("ar_hold_valid", imem.arvalid, 32'd1);
            chk("ar_hold_addr", imem.araddr, addr);
        end
        quiet_inputs();
        imem.arready = 1'b1;
        tick();
        imem.arready = 1'b0;
        chk("ar_drop", imem.arvalid, 32'd0);
        chk("r_ready", imem.rready, 32'd1);
        for (int i = 0; i < r_dly; i++) begin
            npc_valid = 1'($urandom);
            halt_req  = 1'($urandom);
            npc       = $urandom;
            tick();
            chk("r_hold_ready", imem.rready, 32'd1);
            chk("no_early_inst", inst_valid, 32'd0);
            chk("no_halt_busy", halted, 32'd0);
        end
        quiet_inputs();
        imem.rvalid = 1'b1;
        imem.rdata  = data;
        imem.rresp  = resp;
        tick();
        quiet_inputs();
        chk("r_drop", imem.rready, 32'd0);
    endtask

    // OKAY fetch, decode stalls for `hold` cycles, then consumes; ends in the wait-for-npc phase.
    task automatic ok_fetch(input logic [31:0] addr, input int ar_dly, input int r_dly, input int hold);
        logic [31:0] data;
        data = mem_word(addr);
        fetch(addr, ar_dly, r_dly, RESP_OKAY, data);
        exp_cnt = exp_cnt + 32'd1;
        chk("inst_valid", inst_valid, 32'd1);
        chk("inst", inst, data);
        chk("pc", pc, addr);
        chk("fetch_cnt", fetch_cnt, exp_cnt);
        for (int i = 0; i < hold; i++) begin
            npc_valid = 1'($urandom);
            halt_req  = 1'($urandom);
            npc       = $urandom;
            tick();
            chk("hold_valid", inst_valid, 32'd1);
            chk("hold_inst", inst, data);
            chk("hold_pc", pc, addr);
        end
        quiet_inputs();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("wait_no_valid", inst_valid, 32'd0);
        chk("wait_no_ar", imem.arvalid, 32'd0);
    endtask

    task automatic go_npc(input logic [31:0] addr, input int idle);
        for (int i = 0; i < idle; i++) begin
            tick();
            chk("idle_no_ar", imem.arvalid, 32'd0);
            chk("idle_no_valid", inst_valid, 32'd0);
        end
        npc       = addr;
        npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        chk("npc_ar", imem.arvalid, 32'd1);
        chk("npc_addr", imem.araddr, addr);
    endtask

    initial begin
        logic [31:0] a;
        int n;
        mem[RESET_PC] = 32'h0000_0413;
        quiet_inputs();

        // Reset state and zero-wait latency from the first cycle after release.
        do_reset();
        chk("rst_arvalid", imem.arvalid, 32'd0);
        chk("rst_rready", imem.rready, 32'd0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_inst", inst, 32'd0);
        chk("rst_valid", inst_valid, 32'd0);
        chk("rst_err", fetch_err, 32'd0);
        chk("rst_halted", halted, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        imem.arready = 1'b1;
        tick();
        chk("c1_arvalid", imem.arvalid, 32'd1);
        chk("c1_araddr", imem.araddr, RESET_PC);
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hdead_beef;
        tick();
        chk("c2_rready", imem.rready, 32'd1);
        chk("c2_arvalid", imem.arvalid, 32'd0);
        chk("c2_valid", inst_valid, 32'd0);
        imem.arready = 1'b0;
        imem.rdata   = 32'h0000_0413;
        tick();
        quiet_inputs();
        exp_cnt = 32'd1;
        chk("c3_valid", inst_valid, 32'd1);
        chk("c3_inst", inst, 32'h0000_0413);
        chk("c3_pc", pc, RESET_PC);
        chk("c3_cnt", fetch_cnt, exp_cnt);

        // Decode stall, then sequential redirect, then slow memory.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_inst", inst, 32'h0000_0413);
            chk("stall_pc", pc, RESET_PC);
            chk("stall_valid", inst_valid, 32'd1);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        go_npc(32'h8000_0004, 0);
        ok_fetch(32'h8000_0004, 5, 3, 0);
        go_npc(32'h8000_0008, 3);

        // Randomized program flow against the memory/PC model.
        a = 32'h8000_0008;
        for (int k = 0; k < 20; k++) begin
            ok_fetch(a, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
            a = RESET_PC | (32'($urandom_range(0, 63)) << 2);
            go_npc(a, $urandom_range(0, 3));
        end

        // Bus error response: fault, halt, no decode handoff, bus stays quiet.
        fetch(a, 1, 1, 2'b10, 32'h1234_5678);
        chk("berr_err", fetch_err, 32'd1);
        chk("berr_halted", halted, 32'd1);
        chk("berr_valid", inst_valid, 32'd0);
        chk("berr_cnt", fetch_cnt, exp_cnt);
        imem.arready = 1'b1;
        imem.rvalid  = 1'b1;
        halt_req     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("berr_no_ar", imem.arvalid, 32'd0);
            chk("berr_no_r", imem.rready, 32'd0);
            chk("berr_no_valid", inst_valid, 32'd0);
        end

        // halt_req beats npc_valid in the same cycle.
        do_reset();
        ok_fetch(RESET_PC, 0, 0, 1);
        npc       = 32'h8000_0010;
        npc_valid = 1'b1;
        halt_req  = 1'b1;
        tick();
        quiet_inputs();
        chk("hp_halted", halted, 32'd1);
        chk("hp_err", fetch_err, 32'd0);
        chk("hp_pc", pc, RESET_PC);
        repeat (3) tick();
        chk("hp_no_ar", imem.arvalid, 32'd0);

        // Misaligned redirect faults.
        do_reset();
        ok_fetch(RESET_PC, 2, 1, 0);
        npc       = 32'h8000_0002;
        npc_valid = 1'b1;
        tick();
        npc_valid = 1'b0;
        chk("mis_err", fetch_err, 32'd1);
        chk("mis_halted", halted, 32'd1);
        chk("mis_no_ar", imem.arvalid, 32'd0);

        // Address phase never accepted: fault exactly TMO cycles after release.
        do_reset();
        n = 0;
        while (fetch_err !== 1'b1 && n < 4 * TMO) begin
            chk("artmo_ar_up", imem.arvalid, 32'(n != 0));
            tick();
            n++;
        end
        chk("artmo_cycles", n, TMO);
        chk("artmo_halted", halted, 32'd1);
        chk("artmo_ar_drop", imem.arvalid, 32'd0);

        // Data phase never answered: fault TMO cycles after the address is accepted.
        do_reset();
        imem.arready = 1'b1;
        tick();
        tick();
        imem.arready = 1'b0;
        chk("rtmo_rready", imem.rready, 32'd1);
        n = 0;
        while (fetch_err !== 1'b1 && n < 4 * TMO) begin
            tick();
            n++;
        end
        chk("rtmo_cycles", n, TMO);
        chk("rtmo_r_drop", imem.rready, 32'd0);

        // Asynchronous reset in the middle of the data phase, then refetch from RESET_PC.
        do_reset();
        ok_fetch(RESET_PC, 0, 0, 0);
        go_npc(32'h8000_0020, 0);
        imem.arready = 1'b1;
        tick();
        imem.arready = 1'b0;
        chk("ar_mid_rready", imem.rready, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_arvalid", imem.arvalid, 32'd0);
        chk("arst_rready", imem.rready, 32'd0);
        chk("arst_pc", pc, RESET_PC);
        chk("arst_cnt", fetch_cnt, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_cnt = '0;
        ok_fetch(RESET_PC, 0, 2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
